// File: rtl/wb_timer_slave.sv
// -----------------------------------------------------------------------------
// wb_timer_slave
//   Wishbone responder holding a programmable 16-bit timer with a compare
//   match flag and a level interrupt. Classic single-cycle-latency transfers:
//   the cycle after a transfer is accepted carries exactly one of ack or err.
//
//   Register map (wb_adr[2:0]):
//     0 CTRL     [0] en  [1] autoreload  [2] ien
//     1 PRESCALE tick period is PRESCALE+1 cycles
//     2 COMPARE  match value for COUNT+1
//     3 COUNT    timer value, read/write
//     4 STATUS   [0] pend, write 1 to clear
//     5-7        error response, no side effects
//
// Ports
//   i_clk, i_rst         clock, synchronous active-high reset
//   wb_cyc, wb_stb       bus cycle / strobe
//   wb_we                1 = write, 0 = read
//   wb_adr               address; upper bits select this block, [2:0] the register
//   wb_i_dat, wb_sel     write data and byte lanes
//   wb_o_dat             read data, zero whenever wb_ack is low
//   wb_ack, wb_err       transfer / error acknowledge (one cycle)
//   wb_rty               never asserted
//   o_irq                registered STATUS.pend & CTRL.ien
// -----------------------------------------------------------------------------
module wb_timer_slave #(
    parameter int unsigned       ADDR_W    = 24,
    parameter logic [ADDR_W-1:0] BASE      = 24'hF000,
    parameter logic [15:0]       PRESC_RST = 16'h0000
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              wb_cyc,
    input  logic              wb_stb,
    input  logic              wb_we,
    input  logic [ADDR_W-1:0] wb_adr,
    input  logic [15:0]       wb_i_dat,
    input  logic [1:0]        wb_sel,
    output logic [15:0]       wb_o_dat,
    output logic              wb_ack,
    output logic              wb_err,
    output logic              wb_rty,
    output logic              o_irq
);

    localparam logic [2:0] OFF_CTRL     = 3'd0;
    localparam logic [2:0] OFF_PRESCALE = 3'd1;
    localparam logic [2:0] OFF_COMPARE  = 3'd2;
    localparam logic [2:0] OFF_COUNT    = 3'd3;
    localparam logic [2:0] OFF_STATUS   = 3'd4;

    logic [2:0]  ctrl_q, ctrl_d;
    logic [15:0] prescale_q, prescale_d;
    logic [15:0] compare_q, compare_d;
    logic [15:0] count_q, count_d;
    logic [15:0] psc_q, psc_d;
    logic        pend_q, pend_d;
    logic        irq_q, irq_d;
    logic        ack_q, ack_d;
    logic        err_q, err_d;
    logic [15:0] rdat_q, rdat_d;

    logic        hit;
    logic        legal;
    logic        wr;
    logic        count_wr;
    logic        tick;
    logic        match;
    logic        pend_clr;
    logic [15:0] count_inc;
    logic [2:0]  off;

    function automatic logic [15:0] lane_merge(input logic [15:0] old_val,
                                               input logic [15:0] new_val,
                                               input logic [1:0]  sel);
        lane_merge = {sel[1] ? new_val[15:8] : old_val[15:8],
                      sel[0] ? new_val[7:0]  : old_val[7:0]};
    endfunction

    always_comb begin
        off   = wb_adr[2:0];
        // ~ack/~err keeps a still-held strobe from being acknowledged twice.
        hit   = wb_cyc & wb_stb & (wb_adr[ADDR_W-1:3] == BASE[ADDR_W-1:3])
                & ~ack_q & ~err_q;
        legal = (off <= OFF_STATUS);
        wr    = hit & legal & wb_we;
        count_wr = wr & (off == OFF_COUNT);

        ctrl_d     = ctrl_q;
        prescale_d = prescale_q;
        compare_d  = compare_q;
        count_d    = count_q;
        psc_d      = psc_q;
        pend_clr   = 1'b0;
        ack_d      = hit & legal;
        err_d      = hit & ~legal;
        rdat_d     = 16'h0000;

        // Read data reflects register contents before this edge's update.
        if (hit && legal && !wb_we) begin
            case (off)
                OFF_CTRL:     rdat_d = {13'd0, ctrl_q};
                OFF_PRESCALE: rdat_d = prescale_q;
                OFF_COMPARE:  rdat_d = compare_q;
                OFF_COUNT:    rdat_d = count_q;
                OFF_STATUS:   rdat_d = {15'd0, pend_q};
                default:      rdat_d = 16'h0000;
            endcase
        end

        tick = 1'b0;
        if (ctrl_q[0]) begin
            if (psc_q == 16'h0000) begin
                psc_d = prescale_q;
                tick  = 1'b1;
            end else begin
                psc_d = psc_q - 16'd1;
            end
        end

        // A bus write to COUNT on a tick cycle swallows that tick entirely.
        count_inc = count_q + 16'd1;
        match     = tick & ~count_wr & (count_inc == compare_q);
        if (tick && !count_wr) begin
            count_d = (match && ctrl_q[1]) ? 16'h0000 : count_inc;
        end

        if (wr) begin
            case (off)
                OFF_CTRL: begin
                    if (wb_sel[0]) begin
                        ctrl_d = wb_i_dat[2:0];
                        if (wb_i_dat[0]) begin
                            psc_d = prescale_q;
                        end
                    end
                end
                OFF_PRESCALE: prescale_d = lane_merge(prescale_q, wb_i_dat, wb_sel);
                OFF_COMPARE:  compare_d  = lane_merge(compare_q, wb_i_dat, wb_sel);
                OFF_COUNT:    count_d    = lane_merge(count_q, wb_i_dat, wb_sel);
                OFF_STATUS:   pend_clr   = wb_sel[0] & wb_i_dat[0];
                default:      ;
            endcase
        end

        // A match in the same cycle as a clear leaves pend set.
        pend_d = pend_q;
        if (pend_clr) begin
            pend_d = 1'b0;
        end
        if (match) begin
            pend_d = 1'b1;
        end

        irq_d = pend_d & ctrl_d[2];
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ctrl_q     <= 3'd0;
            prescale_q <= PRESC_RST;
            compare_q  <= 16'h0000;
            count_q    <= 16'h0000;
            psc_q      <= 16'h0000;
            pend_q     <= 1'b0;
            irq_q      <= 1'b0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            rdat_q     <= 16'h0000;
        end else begin
            ctrl_q     <= ctrl_d;
            prescale_q <= prescale_d;
            compare_q  <= compare_d;
            count_q    <= count_d;
            psc_q      <= psc_d;
            pend_q     <= pend_d;
            irq_q      <= irq_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            rdat_q     <= rdat_d;
        end
    end

    assign wb_o_dat = rdat_q;
    assign wb_ack   = ack_q;
    assign wb_err   = err_q;
    assign wb_rty   = 1'b0;
    assign o_irq    = irq_q;

endmodule

// File: tb/tb_wb_timer_slave.sv
// -----------------------------------------------------------------------------
// tb_wb_timer_slave
//   Self-checking bench for wb_timer_slave. Each bus transfer pushes its
//   expected response onto a scoreboard queue; a negedge monitor pops and
//   compares whenever the DUT acknowledges. Timer values are predicted from
//   the edge number on which the enabling CTRL write was accepted.
// -----------------------------------------------------------------------------
module tb_wb_timer_slave;

    localparam logic [23:0] BASE_TB = 24'hF000;

    localparam logic [2:0] R_CTRL  = 3'd0;
    localparam logic [2:0] R_PRESC = 3'd1;
    localparam logic [2:0] R_CMP   = 3'd2;
    localparam logic [2:0] R_CNT   = 3'd3;
    localparam logic [2:0] R_STAT  = 3'd4;

    logic        clk = 1'b0;
    logic        i_rst;
    logic        wb_cyc, wb_stb, wb_we;
    logic [23:0] wb_adr;
    logic [15:0] wb_i_dat;
    logic [1:0]  wb_sel;
    logic [15:0] wb_o_dat;
    logic        wb_ack, wb_err, wb_rty;
    logic        o_irq;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc_cnt = 0;

    typedef struct {
        bit          is_err;
        bit          chk_dat;
        logic [15:0] dat;
        string       tag;
    } rsp_t;

    rsp_t sb_q[$];

    wb_timer_slave #(
        .ADDR_W   (24),
        .BASE     (BASE_TB),
        .PRESC_RST(16'h0000)
    ) dut (
        .i_clk   (clk),
        .i_rst   (i_rst),
        .wb_cyc  (wb_cyc),
        .wb_stb  (wb_stb),
        .wb_we   (wb_we),
        .wb_adr  (wb_adr),
        .wb_i_dat(wb_i_dat),
        .wb_sel  (wb_sel),
        .wb_o_dat(wb_o_dat),
        .wb_ack  (wb_ack),
        .wb_err  (wb_err),
        .wb_rty  (wb_rty),
        .o_irq   (o_irq)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Response monitor: every ack/err must match the oldest outstanding transfer.
    always @(negedge clk) begin
        rsp_t r;
        if (wb_ack === 1'b1 || wb_err === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_rsp", 32'({wb_ack, wb_err}), 32'd0);
            end else begin
                r = sb_q.pop_front();
                chk({r.tag, "_ack"}, 32'(wb_ack), 32'(!r.is_err));
                chk({r.tag, "_err"}, 32'(wb_err), 32'(r.is_err));
                if (r.chk_dat) chk({r.tag, "_dat"}, 32'(wb_o_dat), 32'(r.dat));
            end
        end
    end

    // Called right after a negedge; returns right after a negedge, two cycles later.
    task automatic bus(input bit we, input logic [2:0] off, input logic [15:0] dat,
                       input logic [1:0] sel, input bit chk_dat,
                       input logic [15:0] exp_dat, input string tag);
        rsp_t r;
        r.is_err  = (off > R_STAT);
        r.chk_dat = chk_dat;
        r.dat     = exp_dat;
        r.tag     = tag;
        sb_q.push_back(r);
        wb_cyc   = 1'b1;
        wb_stb   = 1'b1;
        wb_we    = we;
        wb_adr   = {BASE_TB[23:3], off};
        wb_i_dat = dat;
        wb_sel   = sel;
        @(negedge clk);
        wb_cyc = 1'b0;
        wb_stb = 1'b0;
        wb_we  = 1'b0;
        @(negedge clk);
        chk({tag, "_1cyc"}, 32'({wb_ack, wb_err}), 32'd0);
        chk({tag, "_dat0"}, 32'(wb_o_dat), 32'd0);
        chk({tag, "_pending"}, 32'(sb_q.size()), 32'd0);
    endtask

    task automatic wr(input logic [2:0] off, input logic [15:0] dat,
                      input logic [1:0] sel, input string tag);
        bus(1'b1, off, dat, sel, (off > R_STAT), 16'h0000, tag);
    endtask

    task automatic rd(input logic [2:0] off, input logic [15:0] exp, input string tag);
        bus(1'b0, off, 16'h0000, 2'b11, 1'b1, (off > R_STAT) ? 16'h0000 : exp, tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a;
        i_rst = 1'b1;
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
        wb_adr = 24'h0; wb_i_dat = 16'h0; wb_sel = 2'b00;
        repeat (3) @(negedge clk);
        chk("rst_ack", 32'(wb_ack), 32'd0);
        chk("rst_err", 32'(wb_err), 32'd0);
        chk("rst_irq", 32'(o_irq), 32'd0);
        chk("rst_dat", 32'(wb_o_dat), 32'd0);
        chk("rst_rty", 32'(wb_rty), 32'd0);
        i_rst = 1'b0;
        for (int i = 0; i < 5; i++) rd(3'(i), 16'h0000, "rst_reg");

        // CTRL write / readback
        wr(R_CTRL, 16'h0007, 2'b11, "t1_wr_ctrl");
        rd(R_CTRL, 16'h0007, "t1_rd_ctrl");
        wr(R_CTRL, 16'h0000, 2'b11, "t1_stop");

        // Prescale 0, compare 3, en+ien: COUNT steps every cycle
        wr(R_CNT, 16'h0000, 2'b11, "t2_cnt0");
        wr(R_STAT, 16'h0001, 2'b11, "t2_clr");
        wr(R_PRESC, 16'h0000, 2'b11, "t2_presc");
        wr(R_CMP, 16'h0003, 2'b11, "t2_cmp");
        a = cyc_cnt + 1;
        wr(R_CTRL, 16'h0005, 2'b11, "t2_ctrl");
        for (int k = 1; k <= 4; k++) begin
            chk("t2_irq", 32'(o_irq), 32'(k >= 3));
            @(negedge clk);
        end
        rd(R_CNT, 16'(cyc_cnt - a), "t2_cnt");
        rd(R_CNT, 16'(cyc_cnt - a), "t2_cnt");
        rd(R_STAT, 16'h0001, "t2_stat");

        // Prescale 2, compare 2, autoreload, no ien
        wr(R_CTRL, 16'h0000, 2'b11, "t3_stop");
        wr(R_CNT, 16'h0000, 2'b11, "t3_cnt0");
        wr(R_STAT, 16'h0001, 2'b11, "t3_clr");
        wr(R_PRESC, 16'h0002, 2'b11, "t3_presc");
        wr(R_CMP, 16'h0002, 2'b11, "t3_cmp");
        a = cyc_cnt + 1;
        wr(R_CTRL, 16'h0003, 2'b11, "t3_ctrl");
        for (int i = 0; i < 6; i++) rd(R_CNT, 16'(((cyc_cnt - a) / 3) % 2), "t3_cnt");
        rd(R_STAT, 16'h0001, "t3_stat");
        chk("t3_irq", 32'(o_irq), 32'd0);
        rd(R_PRESC, 16'h0002, "t3_presc_rd");

        // 0xFFFF -> 0x0000 wrap without a flag
        wr(R_CTRL, 16'h0000, 2'b11, "tw_stop");
        wr(R_PRESC, 16'h0000, 2'b11, "tw_presc");
        wr(R_CMP, 16'h0005, 2'b11, "tw_cmp");
        wr(R_CNT, 16'hFFFE, 2'b11, "tw_cnt");
        wr(R_STAT, 16'h0001, 2'b11, "tw_clr");
        a = cyc_cnt + 1;
        wr(R_CTRL, 16'h0001, 2'b11, "tw_ctrl");
        rd(R_CNT, 16'hFFFE + 16'(cyc_cnt - a), "tw_cnt_rd");
        rd(R_CNT, 16'hFFFE + 16'(cyc_cnt - a), "tw_cnt_rd");
        rd(R_STAT, 16'h0000, "tw_stat");

        // STATUS clear, then clear on the match cycle
        wr(R_CTRL, 16'h0000, 2'b11, "t4_stop");
        wr(R_CNT, 16'h0000, 2'b11, "t4_cnt0");
        wr(R_CMP, 16'h0002, 2'b11, "t4_cmp");
        wr(R_STAT, 16'h0001, 2'b11, "t4_clr0");
        a = cyc_cnt + 1;
        wr(R_CTRL, 16'h0005, 2'b11, "t4_ctrl");
        rd(R_STAT, 16'h0000, "t4_stat_pre");
        chk("t4_irq_set", 32'(o_irq), 32'd1);
        wr(R_STAT, 16'h0001, 2'b11, "t4_clr");
        chk("t4_irq_clr", 32'(o_irq), 32'd0);
        rd(R_STAT, 16'h0000, "t4_stat_clr");
        wr(R_CTRL, 16'h0000, 2'b11, "t4b_stop");
        wr(R_CNT, 16'h0000, 2'b11, "t4b_cnt0");
        wr(R_CTRL, 16'h0005, 2'b11, "t4b_ctrl");
        wr(R_STAT, 16'h0001, 2'b11, "t4b_clr_on_match");
        chk("t4b_irq", 32'(o_irq), 32'd1);
        rd(R_STAT, 16'h0001, "t4b_stat");
        a = cyc_cnt + 1;
        wr(R_CNT, 16'h0100, 2'b11, "t4c_cnt_wr");
        rd(R_CNT, 16'h0100 + 16'(cyc_cnt - a), "t4c_cnt_rd");

        // Byte lanes, error offsets, outside window
        wr(R_CTRL, 16'h0000, 2'b11, "t5_stop");
        wr(R_CMP, 16'h1234, 2'b11, "t5_cmp");
        wr(R_CMP, 16'hABCD, 2'b10, "t5_cmp_hi");
        rd(R_CMP, 16'hAB34, "t5_cmp_rd");
        wr(R_CMP, 16'h5555, 2'b00, "t5_cmp_none");
        rd(R_CMP, 16'hAB34, "t5_cmp_rd2");
        wr(R_CMP, 16'h00EF, 2'b01, "t5_cmp_lo");
        rd(R_CMP, 16'hABEF, "t5_cmp_rd3");
        rd(3'd6, 16'h0000, "t5_rd6");
        wr(3'd5, 16'hFFFF, 2'b11, "t5_wr5");
        rd(3'd7, 16'h0000, "t5_rd7");
        rd(R_CMP, 16'hABEF, "t5_cmp_rd4");
        rd(R_PRESC, 16'h0000, "t5_presc_rd");
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0;
        wb_adr = {BASE_TB[23:3] + 21'd1, 3'd0};
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("t5_outside", 32'({wb_ack, wb_err}), 32'd0);
        end
        wb_cyc = 1'b0; wb_stb = 1'b0;
        @(negedge clk);

        // Reset during an accepted strobe
        wr(R_CNT, 16'h0000, 2'b11, "t6_cnt0");
        wr(R_CMP, 16'h0001, 2'b11, "t6_cmp");
        wr(R_PRESC, 16'h0000, 2'b11, "t6_presc0");
        wr(R_CTRL, 16'h0007, 2'b11, "t6_ctrl");
        wr(R_PRESC, 16'h0005, 2'b11, "t6_presc");
        chk("t6_irq_pre", 32'(o_irq), 32'd1);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0;
        wb_adr = {BASE_TB[23:3], R_PRESC};
        i_rst = 1'b1;
        @(negedge clk);
        chk("t6_ack", 32'(wb_ack), 32'd0);
        chk("t6_err", 32'(wb_err), 32'd0);
        chk("t6_dat", 32'(wb_o_dat), 32'd0);
        chk("t6_irq", 32'(o_irq), 32'd0);
        i_rst = 1'b0;
        wb_cyc = 1'b0; wb_stb = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 5; i++) rd(3'(i), 16'h0000, "t6_reg");

        repeat (2) @(negedge clk);
        chk("final_pending", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
